beta_fetch_pc: RTL and testbench
================================

Name: beta_fetch_pc

Overview:
- Instruction-fetch and program-counter stage of the Beta datapath. It sits directly upstream of the control unit.
- Holds the PC and supervisor bit (PC[31]), and fetches from instruction memory with a req/ready handshake.
- Presents a stable 32-bit instruction to the control unit, then computes the next PC from the control unit's PCSEL when the execute stage signals completion.
- Also handles the external interrupt (XAdr) entry.

Parameters:
- RESET_VEC, 32'h80000000, PC loaded on reset (supervisor mode).
- ILLOP_VEC, 32'h80000004, target for PCSEL=3 and any undefined PCSEL.
- XADR_VEC, 32'h80000008, target for PCSEL=4 and for a taken interrupt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pcsel  input  3  next-PC select from the control unit: 0 PC+4, 1 branch, 2 JMP, 3 ILLOP, 4 XAdr.
- ra_data  input  32  Reg[Ra] value, used as the JMP target.
- literal  input  16  instruction[15:0], the branch displacement in words.
- advance  input  1  execute stage has consumed the current instruction; PC update is permitted.
- irq  input  1  external interrupt request, level or pulse.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  fetch address, {1'b0, pc[30:2], 2'b00}.
- imem_rdata  input  32  instruction memory read data.
- imem_ready  input  1  read data valid this cycle.
- instruction  output  32  registered instruction to the control unit.
- instr_valid  output  1  instruction is valid and held stable.
- pc  output  32  current PC, including the supervisor bit.
- pc_plus4  output  32  {pc[31], pc[30:0]+4}; write-back source for WDSEL=0.
- irq_ack  output  1  one-cycle pulse when an interrupt is taken.
- xp_out  output  32  resume address captured when the interrupt is taken.

Behaviour:
- Reset (synchronous, takes precedence over everything):
  - pc=RESET_VEC, state=IDLE, instruction=0, instr_valid=0, imem_req=0.
  - irq_pending=0, irq_ack=0, xp_out=0.
- States:
  - IDLE: imem_req=0. Always moves to FETCH on the next edge.
  - FETCH: imem_req=1, imem_addr driven from pc. If imem_ready is high on an edge, latch instruction<=imem_rdata and go to VALID. Otherwise remain in FETCH with address stable (any number of wait states).
  - VALID: instr_valid=1, imem_req=0, instruction held. If advance is high on an edge, load next PC and go to FETCH. Otherwise hold.
- Minimum throughput: 2 cycles per instruction (zero-wait memory, advance asserted in the first VALID cycle).
- imem_ready is ignored outside FETCH; advance is ignored outside VALID.
- Next PC on advance, all arithmetic modulo 2^31 on bits [30:0]:
  - pcsel 0: pc_plus4.
  - pcsel 1: {pc_plus4[31], pc_plus4[30:0] + (sign-extended literal << 2)}. The supervisor bit is preserved.
  - pcsel 2: {pc[31] & ra_data[31], ra_data[30:2], 2'b00}. JMP can clear the supervisor bit but never set it; the low bits are forced to 0.
  - pcsel 3, 5, 6, 7: ILLOP_VEC.
  - pcsel 4: XADR_VEC.
- Interrupt:
  - irq high on any edge sets irq_pending.
  - Interrupt is taken on an advance edge when irq_pending=1 and pc[31]=0 (user mode). It overrides pcsel:
    - next pc=XADR_VEC;
    - xp_out<=the PC that pcsel would have selected;
    - irq_pending<=0;
    - irq_ack=1 for exactly the following cycle.
  - In supervisor mode, irq_pending is held until a user-mode advance occurs.
  - irq arriving on the same edge an interrupt is taken leaves irq_pending=1.
- Wrap-around: pc[30:0]=0x7FFFFFFC plus 4 gives 0x00000000 in bits [30:0]; bit 31 is unchanged.
- Reset in FETCH or VALID: any in-flight fetch is abandoned, and memory data returned later in IDLE is ignored. Fetching restarts at RESET_VEC.

Test Plan:
- Reset then zero-wait memory, advance=1, pcsel=0 -> imem_addr sequence 0x00000000, 0x00000004, 0x00000008; pc=0x80000000, 0x80000004, 0x80000008; imem_req first high on the 2nd cycle after reset falls.
- Memory with 3 wait states -> imem_req and imem_addr held 4 cycles; instruction latched only on the ready edge; instr_valid low throughout FETCH.
- pc=0x00000100, pcsel=1, literal=16'hFFFE -> next pc=0x000000FC; literal=16'h0003 -> next pc=0x00000110.
- pc=0x80000010, pcsel=2, ra_data=0x00000207 -> pc=0x00000204; then from user mode, ra_data=0x80000300 -> pc=0x00000300 (supervisor bit not gained).
- pc=0x00000040, irq pulse, then advance with pcsel=0 -> pc=0x80000008, xp_out=0x00000044, irq_ack one cycle. The same sequence in supervisor mode -> no interrupt taken, irq_pending retained.
- Reset asserted mid-FETCH with imem_ready arriving one cycle later -> instruction stays 0, instr_valid=0, refetch from 0x00000000 with pc=0x80000000. pcsel=6 -> pc=0x80000004.

Source files
------------

// File: rtl/beta_fetch_pc_if.sv
// Instruction-memory read port of the Beta fetch stage.
// The fetch stage is the master (it drives req/addr); the memory is the slave.
interface beta_fetch_pc_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/beta_fetch_pc.sv
// Beta instruction-fetch / program-counter stage: holds PC and supervisor bit,
// fetches over a req/ready port, selects the next PC and enters interrupts.
module beta_fetch_pc #(
    parameter logic [31:0] RESET_VEC = 32'h80000000,
    parameter logic [31:0] ILLOP_VEC = 32'h80000004,
    parameter logic [31:0] XADR_VEC  = 32'h80000008
) (
    input  logic                   clk,
    input  logic                   reset,
    beta_fetch_pc_if.master        imem,
    input  logic [2:0]             i_pcsel,
    input  logic [31:0]            i_ra_data,
    input  logic [15:0]            i_literal,
    input  logic                   i_advance,
    input  logic                   i_irq,
    output logic [31:0]            o_instruction,
    output logic                   o_instr_valid,
    output logic [31:0]            o_pc,
    output logic [31:0]            o_pc_plus4,
    output logic                   o_irq_ack,
    output logic [31:0]            o_xp_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_irqPending;
    logic        r_irqAck;
    logic [31:0] r_xp;

    logic [31:0] w_pcPlus4;
    logic [30:0] w_branchOffset;
    logic [31:0] w_selPc;
    logic        w_fetchDone;
    logic        w_advance;
    logic        w_takeIrq;
    logic        w_unusedRaLow;

    // JMP targets are word aligned, so the two low bits of Ra never matter.
    assign w_unusedRaLow  = ^i_ra_data[1:0];

    // PC arithmetic wraps in bits [30:0]; bit 31 (supervisor) rides along untouched.
    assign w_pcPlus4      = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_branchOffset = {{13{i_literal[15]}}, i_literal, 2'b00};

    assign w_fetchDone    = (r_state == S_FETCH) && imem.imem_ready;
    assign w_advance      = (r_state == S_VALID) && i_advance;
    assign w_takeIrq      = w_advance && r_irqPending && !r_pc[31];

    always_comb begin
        w_selPc = ILLOP_VEC;
        case (i_pcsel)
            3'd0:    w_selPc = w_pcPlus4;
            3'd1:    w_selPc = {w_pcPlus4[31], w_pcPlus4[30:0] + w_branchOffset};
            3'd2:    w_selPc = {r_pc[31] & i_ra_data[31], i_ra_data[30:2], 2'b00};
            3'd4:    w_selPc = XADR_VEC;
            default: w_selPc = ILLOP_VEC;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  w_nextState = S_FETCH;
            S_FETCH: if (imem.imem_ready) w_nextState = S_VALID;
            S_VALID: if (i_advance)       w_nextState = S_FETCH;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A taken interrupt records the PC that pcsel would have chosen as the resume point.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_VEC;
            r_instruction <= 32'h0;
            r_irqPending  <= 1'b0;
            r_irqAck      <= 1'b0;
            r_xp          <= 32'h0;
        end else begin
            r_irqAck <= w_takeIrq;
            if (i_irq) begin
                r_irqPending <= 1'b1;
            end else if (w_takeIrq) begin
                r_irqPending <= 1'b0;
            end
            if (w_fetchDone) begin
                r_instruction <= imem.imem_rdata;
            end
            if (w_advance) begin
                r_pc <= w_takeIrq ? XADR_VEC : w_selPc;
                if (w_takeIrq) begin
                    r_xp <= w_selPc;
                end
            end
        end
    end

    assign imem.imem_req   = (r_state == S_FETCH);
    assign imem.imem_addr  = {1'b0, r_pc[30:2], 2'b00};
    assign o_instruction   = r_instruction;
    assign o_instr_valid   = (r_state == S_VALID);
    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pcPlus4;
    assign o_irq_ack       = r_irqAck;
    assign o_xp_out        = r_xp;

    a_reqValidExclusive: assert property (@(posedge clk) disable iff (reset)
        !(imem.imem_req && o_instr_valid));

    a_ackSingleCycle: assert property (@(posedge clk) disable iff (reset)
        o_irq_ack |=> !o_irq_ack);

endmodule

// File: tb/tb_beta_fetch_pc.sv
// Scoreboard bench for beta_fetch_pc: directed advances push expected fetch
// addresses, PCs and interrupt acks; a negedge monitor pops and compares.
module tb_beta_fetch_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cycles;
    } validExp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  pcsel = 3'd0;
    logic [31:0] raData = 32'h0;
    logic [15:0] literal = 16'h0;
    logic        advance = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        irqAck;
    logic [31:0] xpOut;

    int checks = 0;
    int failures = 0;

    logic [31:0] fetchQ[$];
    validExp_t   validQ[$];
    logic [31:0] ackQ[$];

    int          waitStates = 0;
    int          waitCnt = 0;
    logic        memAuto = 1'b1;
    logic        forceReady = 1'b0;
    logic [31:0] forceData = 32'h0;

    logic        prevReq = 1'b0;
    logic        prevValid = 1'b0;
    logic        prevAck = 1'b0;
    logic [31:0] prevAddr = 32'h0;
    logic [31:0] prevInstr = 32'h0;
    int          reqCycles = 0;
    validExp_t   vExp;
    logic [31:0] aExp;

    beta_fetch_pc_if bus();

    beta_fetch_pc dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus),
        .i_pcsel       (pcsel),
        .i_ra_data     (raData),
        .i_literal     (literal),
        .i_advance     (advance),
        .i_irq         (irq),
        .o_instruction (instruction),
        .o_instr_valid (instrValid),
        .o_pc          (pc),
        .o_pc_plus4    (pcPlus4),
        .o_irq_ack     (irqAck),
        .o_xp_out      (xpOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'hCAFE, a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Instruction memory: answers one step after the clock edge, with optional wait states.
    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            #1;
            if (!memAuto) begin
                bus.imem_ready = forceReady;
                bus.imem_rdata = forceData;
                waitCnt = 0;
            end else if (bus.imem_req) begin
                if (waitCnt >= waitStates) begin
                    bus.imem_ready = 1'b1;
                    bus.imem_rdata = memWord(bus.imem_addr);
                    waitCnt = 0;
                end else begin
                    bus.imem_ready = 1'b0;
                    bus.imem_rdata = 32'hDEADBEEF;
                    waitCnt++;
                end
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = 32'hDEADBEEF;
                waitCnt = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues on falling edges.
    always @(negedge clk) begin
        if (bus.imem_req) begin
            reqCycles = prevReq ? reqCycles + 1 : 1;
        end
        if (bus.imem_req && !prevReq) begin
            if (fetchQ.size() == 0) begin
                checkOutput("unexpectedFetch", bus.imem_addr, 32'hFFFFFFFF);
            end else begin
                aExp = fetchQ.pop_front();
                checkOutput("fetchAddr", bus.imem_addr, aExp);
            end
        end
        if (bus.imem_req && prevReq) begin
            checkOutput("addrStable", bus.imem_addr, prevAddr);
            checkOutput("instrHeld", instruction, prevInstr);
            checkOutput("validLowInFetch", {31'b0, instrValid}, 32'h0);
        end
        if (instrValid && !prevValid) begin
            if (validQ.size() == 0) begin
                checkOutput("unexpectedValid", pc, 32'hFFFFFFFF);
            end else begin
                vExp = validQ.pop_front();
                checkOutput("pc", pc, vExp.pc);
                checkOutput("instruction", instruction, vExp.instr);
                checkOutput("pcPlus4", pcPlus4, {vExp.pc[31], vExp.pc[30:0] + 31'd4});
                checkOutput("fetchCycles", reqCycles, vExp.cycles);
            end
        end
        if (irqAck) begin
            checkOutput("ackSingle", {31'b0, prevAck}, 32'h0);
            if (ackQ.size() == 0) begin
                checkOutput("unexpectedAck", xpOut, 32'hFFFFFFFF);
            end else begin
                aExp = ackQ.pop_front();
                checkOutput("xpOut", xpOut, aExp);
            end
        end
        prevReq   = bus.imem_req;
        prevValid = instrValid;
        prevAck   = irqAck;
        prevAddr  = bus.imem_addr;
        prevInstr = instruction;
    end

    // Waits for a valid instruction, then advances with the given select; irqMode 1 pulses
    // irq before the advance, irqMode 2 holds irq high on the advance edge itself.
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] ra, input logic [15:0] lit,
                                 input int irqMode, input logic [31:0] expPc, input logic expIrq,
                                 input logic [31:0] expXp, input int waits);
        int cnt = 0;
        while (!instrValid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!instrValid) begin
            checks++;
            failures++;
            $display("[TB] FAIL validTimeout actual=0 expected=1");
            return;
        end
        fetchQ.push_back({1'b0, expPc[30:2], 2'b00});
        validQ.push_back('{expPc, memWord({1'b0, expPc[30:2], 2'b00}), waits + 1});
        if (expIrq) ackQ.push_back(expXp);
        waitStates = waits;
        if (irqMode == 1) begin
            irq = 1'b1;
            @(negedge clk);
            irq = 1'b0;
        end
        pcsel   = sel;
        raData  = ra;
        literal = lit;
        advance = 1'b1;
        if (irqMode == 2) irq = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        irq     = 1'b0;
        pcsel   = 3'd0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstPc", pc, 32'h80000000);
        checkOutput("rstValid", {31'b0, instrValid}, 32'h0);
        checkOutput("rstReq", {31'b0, bus.imem_req}, 32'h0);
        checkOutput("rstInstr", instruction, 32'h0);
        checkOutput("rstAck", {31'b0, irqAck}, 32'h0);
        checkOutput("rstXp", xpOut, 32'h0);
        fetchQ.push_back(32'h00000000);
        validQ.push_back('{32'h80000000, memWord(32'h0), 1});
        reset = 1'b0;

        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h80000004, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h80000008, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h8000000C, 1'b0, 32'h0,        3);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h80000010, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000207, 16'h0,    0, 32'h00000204, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h80000300, 16'h0,    0, 32'h00000300, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000100, 16'h0,    0, 32'h00000100, 1'b0, 32'h0,        0);
        applyStimulus(3'd1, 32'h0,        16'hFFFE, 0, 32'h000000FC, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000100, 16'h0,    0, 32'h00000100, 1'b0, 32'h0,        0);
        applyStimulus(3'd1, 32'h0,        16'h0003, 0, 32'h00000110, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000040, 16'h0,    0, 32'h00000040, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    1, 32'h80000008, 1'b1, 32'h00000044, 0);
        applyStimulus(3'd0, 32'h0,        16'h0,    1, 32'h8000000C, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000200, 16'h0,    0, 32'h00000200, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h80000008, 1'b1, 32'h00000204, 0);
        applyStimulus(3'd2, 32'h00000300, 16'h0,    1, 32'h00000300, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    2, 32'h80000008, 1'b1, 32'h00000304, 0);
        applyStimulus(3'd2, 32'h00000400, 16'h0,    0, 32'h00000400, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h80000008, 1'b1, 32'h00000404, 0);
        applyStimulus(3'd6, 32'h0,        16'h0,    0, 32'h80000004, 1'b0, 32'h0,        0);
        applyStimulus(3'd3, 32'h0,        16'h0,    0, 32'h80000004, 1'b0, 32'h0,        0);
        applyStimulus(3'd4, 32'h0,        16'h0,    0, 32'h80000008, 1'b0, 32'h0,        0);
        applyStimulus(3'd7, 32'h0,        16'h0,    0, 32'h80000004, 1'b0, 32'h0,        0);
        applyStimulus(3'd5, 32'h0,        16'h0,    0, 32'h80000004, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h7FFFFFFC, 16'h0,    0, 32'h7FFFFFFC, 1'b0, 32'h0,        0);
        applyStimulus(3'd0, 32'h0,        16'h0,    0, 32'h00000000, 1'b0, 32'h0,        0);
        applyStimulus(3'd2, 32'h00000013, 16'h0,    0, 32'h00000010, 1'b0, 32'h0,        0);
        applyStimulus(3'd1, 32'h0,        16'h8000, 0, 32'h7FFE0014, 1'b0, 32'h0,        0);

        // Abandon a fetch with reset; late ready data during IDLE must be dropped.
        cnt = 0;
        while (!instrValid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        memAuto    = 1'b0;
        forceReady = 1'b0;
        fetchQ.push_back(32'h7FFE0018);
        pcsel   = 3'd0;
        advance = 1'b1;
        @(negedge clk);
        advance    = 1'b0;
        reset      = 1'b1;
        forceReady = 1'b1;
        forceData  = 32'h12345678;
        @(negedge clk);
        checkOutput("midRstInstr", instruction, 32'h0);
        checkOutput("midRstValid", {31'b0, instrValid}, 32'h0);
        checkOutput("midRstReq", {31'b0, bus.imem_req}, 32'h0);
        checkOutput("midRstPc", pc, 32'h80000000);
        checkOutput("midRstXp", xpOut, 32'h0);
        reset      = 1'b0;
        forceReady = 1'b0;
        fetchQ.push_back(32'h00000000);
        validQ.push_back('{32'h80000000, memWord(32'h0), 2});
        @(negedge clk);
        checkOutput("lateReadyInstr", instruction, 32'h0);
        checkOutput("lateReadyValid", {31'b0, instrValid}, 32'h0);
        checkOutput("refetchReq", {31'b0, bus.imem_req}, 32'h1);
        checkOutput("refetchPc", pc, 32'h80000000);
        memAuto = 1'b1;

        applyStimulus(3'd6, 32'h0, 16'h0, 0, 32'h80000004, 1'b0, 32'h0, 0);

        cnt = 0;
        while ((fetchQ.size() != 0 || validQ.size() != 0 || ackQ.size() != 0) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        checkOutput("fetchQDrained", fetchQ.size(), 32'h0);
        checkOutput("validQDrained", validQ.size(), 32'h0);
        checkOutput("ackQDrained", ackQ.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
